// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative RV32M divider for DIV/DIVU/REM/REMU in the EXE stage.
//   It is a radix-2 restoring divider that produces one quotient bit per cycle.
//   Divide-by-zero and signed overflow finish in a single cycle.
//   While a divide is in progress, div_running asks the stall/flush controller
//   to freeze IF/ID/EXE.
//
// Optional feature (macro DIV_RESULT_CACHE_EN):
//   A single-entry result cache stores the operands and both corrected results
//   of the last normal-path divide. A repeat of the same operands with the same
//   signedness then completes in one cycle.
//
// Parameters:
//   WIDTH        operand/result width
//   CNT_W        iteration counter width (2**CNT_W > WIDTH)
//
// Ports:
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   start        EXE holds a valid divide instruction
//   op           funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op_a, op_b   dividend (rs1), divisor (rs2)
//   flush        abort the current operation (active-high)
//   div_running  stall request to the pipeline controller
//   div_done     one-cycle strobe, result valid while high
//   result       quotient or remainder, selected by op
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             div_running,
    output logic             div_done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             sign_q;
    logic             sign_r;
    logic             rem_sel;

    // Decode the incoming instruction.
    // Magnitudes are taken only for signed ops. |0x80000000| stays
    // 0x80000000 and is treated as an unsigned value.
    logic             is_signed_in;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        is_signed_in = ~op[0];
        a_neg        = is_signed_in & op_a[WIDTH-1];
        b_neg        = is_signed_in & op_b[WIDTH-1];
        a_abs        = a_neg ? (~op_a + 1'b1) : op_a;
        b_abs        = b_neg ? (~op_b + 1'b1) : op_b;
        div_zero     = (op_b == '0);
        ovf          = is_signed_in && (op_a == MIN_NEG) && (op_b == '1);
        if (div_zero)
            special_res = op[1] ? op_a : '1;
        else
            special_res = op[1] ? '0 : MIN_NEG;
    end

    // One restoring step.
    // The trial subtraction is WIDTH+1 bits wide so that its sign bit
    // is kept. A non-negative trial means the divisor fits, so that
    // quotient bit is 1.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        trial_ok = ~trial[WIDTH];
        rem_next = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], trial_ok};
        q_fix    = sign_q ? (~quo_next + 1'b1) : quo_next;
        r_fix    = sign_r ? (~rem_next + 1'b1) : rem_next;
    end

    // The stall request is combinational.
    // It therefore takes effect in the start cycle itself, and a flush
    // masks it in the same cycle.
    always_comb begin
        div_running = ((state == IDLE) && start && !flush) ||
                      ((state == BUSY) && !flush);
    end

    logic             cache_hit;
    logic [WIDTH-1:0] cache_result;
    logic             complete;

    assign complete = (state == BUSY) && !flush && (cnt == CNT_W'(1));

`ifdef DIV_RESULT_CACHE_EN
    logic             cache_valid;
    logic [WIDTH-1:0] cache_a;
    logic [WIDTH-1:0] cache_b;
    logic             cache_signed;
    logic [WIDTH-1:0] cache_q;
    logic [WIDTH-1:0] cache_r;
    logic [WIDTH-1:0] key_a;
    logic [WIDTH-1:0] key_b;
    logic             key_signed;

    // DIV and REM share an entry, and DIVU and REMU share an entry.
    // op[1] only chooses which stored half is returned.
    always_comb begin
        cache_hit    = cache_valid && (op_a == cache_a) && (op_b == cache_b) &&
                       (is_signed_in == cache_signed);
        cache_result = op[1] ? cache_r : cache_q;
    end

    // The raw operands are latched at start and become the cache key.
    // The key is committed when the iteration finishes normally.
    // A flush leaves the stored entry intact; only reset invalidates it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cache_valid  <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_signed <= 1'b0;
            cache_q      <= '0;
            cache_r      <= '0;
            key_a        <= '0;
            key_b        <= '0;
            key_signed   <= 1'b0;
        end else begin
            if ((state == IDLE) && start && !flush) begin
                key_a      <= op_a;
                key_b      <= op_b;
                key_signed <= is_signed_in;
            end
            if (complete) begin
                cache_valid  <= 1'b1;
                cache_a      <= key_a;
                cache_b      <= key_b;
                cache_signed <= key_signed;
                cache_q      <= q_fix;
                cache_r      <= r_fix;
            end
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    // Main control FSM.
    // Special cases and cache hits go straight to DONE with the result
    // loaded on the same edge. Normal divides iterate WIDTH times in BUSY.
    // Flush wins over everything else and never touches result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            rem_sel  <= 1'b0;
            div_done <= 1'b0;
            result   <= '0;
        end else begin
            div_done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rem_sel <= op[1];
                            divisor <= b_abs;
                            quo     <= a_abs;
                            rem     <= '0;
                            sign_q  <= a_neg ^ b_neg;
                            sign_r  <= a_neg;
                            if (div_zero || ovf) begin
                                result   <= special_res;
                                div_done <= 1'b1;
                                state    <= DONE;
                            end else if (cache_hit) begin
                                result   <= cache_result;
                                div_done <= 1'b1;
                                state    <= DONE;
                            end else begin
                                cnt   <= CNT_W'(WIDTH);
                                state <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt - 1'b1;
                        if (complete) begin
                            result   <= rem_sel ? r_fix : q_fix;
                            div_done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit.
//   It applies a table of directed vectors back to back, then hand-written
//   flush and reset sequences, then randomized operations. The randomized
//   results are checked against an arithmetic reference model.
//   Build with DIV_RESULT_CACHE_EN defined to check the cached-latency path.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        div_running;
    logic        div_done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    // Model of the single cache entry, kept at the operation level.
    bit          mc_valid = 1'b0;
    logic [31:0] mc_a;
    logic [31:0] mc_b;
    bit          mc_s;

    logic [31:0] last_result = 32'h0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .op          (op),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .div_running (div_running),
        .div_done    (div_done),
        .result      (result)
    );

    // Free-running clock with a 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The RISC-V divide rules, written with plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        int  sa;
        int  sb;
        bit  ov;
        sa = a;
        sb = b;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'd0: return (b == 0) ? 32'hFFFF_FFFF : (ov ? 32'h8000_0000 : 32'(sa / sb));
            2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: return (b == 0) ? a : (ov ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected cycles from start to div_done. Calling it also updates the
    // cache model, as the DUT would when the operation completes.
    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        bit sgn;
        bit special;
        bit hit;
        sgn     = ~o[0];
        special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit     = CACHE && mc_valid && (a == mc_a) && (b == mc_b) && (sgn == mc_s);
        if (special || hit)
            return 1;
        mc_valid = 1'b1;
        mc_a     = a;
        mc_b     = b;
        mc_s     = sgn;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
        start = s;
        op    = o;
        op_a  = a;
        op_b  = b;
    endtask

    // Start one divide in the cycle after the current edge. The task checks
    // the stall shape, the done timing and the result. It leaves start high
    // through DONE, as the pipeline does.
    task automatic run_div(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int lat;
        int cyc;
        int gaps;
        lat = ref_latency(o, a, b);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, o, a, b);
        #1;
        checkOutput({name, "_run_at_T"}, 32'(div_running), 32'd1);
        cyc  = 0;
        gaps = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (div_done)
                break;
            if (!div_running)
                gaps++;
        end
        checkOutput({name, "_latency"}, 32'(cyc), 32'(lat));
        checkOutput({name, "_result"}, result, exp);
        checkOutput({name, "_run_gaps"}, 32'(gaps), 32'd0);
        checkOutput({name, "_run_in_done"}, 32'(div_running), 32'd0);
        last_result = exp;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(1'b0, 2'd0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        int          dones;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] pa;
        logic [31:0] pb;
        int          sel;

        vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[5]  = '{2'd3, 32'd5,          32'd0,          32'd5};
        vecs[6]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[7]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0};
        vecs[8]  = '{2'd0, 32'd100,        32'd7,          32'd14};
        vecs[9]  = '{2'd2, 32'd100,        32'd7,          32'd2};
        vecs[10] = '{2'd1, 32'd100,        32'd7,          32'd14};
        vecs[11] = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[12] = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[13] = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[14] = '{2'd0, 32'h8000_0000,  32'd2,          32'hC000_0000};

        nrst  = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 2'd0, 32'h0, 32'h0);
        #12;
        checkOutput("reset_running", 32'(div_running), 32'd0);
        checkOutput("reset_done", 32'(div_done), 32'd0);
        checkOutput("reset_result", result, 32'h0);
        nrst = 1'b1;
        idle_cycles(2);

        // The directed table is applied back to back, with each start in
        // the cycle right after the previous DONE.
        for (int i = 0; i < 15; i++)
            run_div($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        idle_cycles(2);

        // Flush at T+10 of DIVU 1000/3, then DIVU 9/3 started at T+12.
        dones = 0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 2'd1, 32'd1000, 32'd3);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (div_done)
                dones++;
        end
        flush = 1'b1;
        #1;
        checkOutput("flush_masks_running", 32'(div_running), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        applyStimulus(1'b0, 2'd1, 32'd1000, 32'd3);
        #1;
        if (div_done)
            dones++;
        checkOutput("flush_idle_running", 32'(div_running), 32'd0);
        checkOutput("flush_no_done", 32'(dones), 32'd0);
        checkOutput("flush_result_held", result, last_result);
        run_div("after_flush", 2'd1, 32'd9, 32'd3, 32'd3);
        idle_cycles(1);

        // Flush together with start in IDLE must not start an operation.
        @(posedge clk);
        #1;
        flush = 1'b1;
        applyStimulus(1'b1, 2'd1, 32'd77, 32'd5);
        #1;
        checkOutput("flush_vs_start_running", 32'(div_running), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        applyStimulus(1'b0, 2'd0, 32'h0, 32'h0);
        #1;
        checkOutput("flush_vs_start_idle", 32'(div_running), 32'd0);

        // Asynchronous reset in the middle of BUSY.
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 2'd1, 32'd50, 32'd5);
        repeat (5) @(posedge clk);
        #3;
        nrst = 1'b0;
        applyStimulus(1'b0, 2'd0, 32'h0, 32'h0);
        #1;
        checkOutput("mid_reset_running", 32'(div_running), 32'd0);
        checkOutput("mid_reset_done", 32'(div_done), 32'd0);
        checkOutput("mid_reset_result", result, 32'h0);
        mc_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        idle_cycles(2);
        run_div("post_reset", 2'd0, 32'd100, 32'd7, 32'd14);

        // Randomized operations are checked against the reference model.
        pa = 32'd100;
        pb = 32'd7;
        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: begin ra = pa; rb = pb; end
                4: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_div($sformatf("rand%0d", i), ro, ra, rb, ref_result(ro, ra, rb));
            pa = ra;
            pb = rb;
        end
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
